stats_display: RTL and testbench

STATS_DISPLAY -- requirements
Module: stats_display

---
 rtl/stats_display_pkg.sv | 53 +++++
 rtl/btn_debounce.sv | 58 +++++
 rtl/stats_display.sv | 141 ++++++++++++++
 tb/tb_stats_display.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stats_display_pkg.sv
// Shared definitions for the statistics display: counter-select state
// encodings, the hex-to-seven-segment table and small helper functions.
package stats_display_pkg;

   // Which performance counter is currently routed to the display.
   typedef enum logic [1:0] {
      SHOW_TOTAL  = 2'd0,
      SHOW_COND   = 2'd1,
      SHOW_UNCOND = 2'd2,
      SHOW_SUCC   = 2'd3
   } sel_state_t;

   // Active-low cathode patterns {dp,g,f,e,d,c,b,a}; entry n encodes hex digit n.
   localparam logic [15:0][7:0] HEX_SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   // All cathodes off, used for blanked leading zeros.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Look up the segment pattern for one nibble.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      return HEX_SEG_TABLE[nib];
   endfunction

   // Cyclic successor in the select order total -> cond -> uncond -> succ.
   function automatic sel_state_t next_sel(input sel_state_t cur);
      sel_state_t nxt;
      case (cur)
         SHOW_TOTAL:  nxt = SHOW_COND;
         SHOW_COND:   nxt = SHOW_UNCOND;
         SHOW_UNCOND: nxt = SHOW_SUCC;
         SHOW_SUCC:   nxt = SHOW_TOTAL;
         default:     nxt = SHOW_TOTAL;
      endcase
      return nxt;
   endfunction

   // One-hot indicator pattern for a select state.
   function automatic logic [3:0] sel_led(input sel_state_t cur);
      logic [3:0] pat;
      case (cur)
         SHOW_TOTAL:  pat = 4'b0001;
         SHOW_COND:   pat = 4'b0010;
         SHOW_UNCOND: pat = 4'b0100;
         SHOW_SUCC:   pat = 4'b1000;
         default:     pat = 4'b0001;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: two-flop synchronizer, counting debouncer and
// rising-edge detector producing a single-cycle pulse per accepted press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          rise_r;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
      end
   end

   // Accept a new level only after it has disagreed for the full window;
   // the pulse fires in the same edge that the level goes 0 -> 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_r <= 1'b0;
         cnt_r   <= '0;
         rise_r  <= 1'b0;
      end else if (sync2_r != level_r) begin
         if (cnt_r == CNT_LAST) begin
            level_r <= sync2_r;
            cnt_r   <= '0;
            rise_r  <= sync2_r;
         end else begin
            cnt_r   <= cnt_r + CW'(1);
            rise_r  <= 1'b0;
         end
      end else begin
         cnt_r  <= '0;
         rise_r <= 1'b0;
      end
   end

   assign level = level_r;
   assign rise  = rise_r;

endmodule

// File: rtl/stats_display.sv
// Multiplexed eight-digit hex display of one of four performance counters,
// selected by a debounced push-button, with an optional freeze of the value.
module stats_display #(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] total,
   input  logic [31:0] conditional,
   input  logic [31:0] unconditional,
   input  logic [31:0] conditional_success,
   input  logic        btn_next,
   input  logic        freeze,
   output logic [7:0]  seg,
   output logic [7:0]  an,
   output logic [3:0]  led
);

   import stats_display_pkg::*;

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic          btn_level_s;
   logic          adv_s;
   sel_state_t    state_r;
   logic          state_chg_r;
   logic [3:0]    led_r;
   logic [31:0]   value_r;
   logic [31:0]   sel_value_s;
   logic [PW-1:0] presc_r;
   logic [2:0]    digit_r;
   logic [31:0]   shifted_s;
   logic          blank_s;
   logic [7:0]    seg_r;
   logic [7:0]    an_r;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_next),
      .level (btn_level_s),
      .rise  (adv_s)
   );

   // Select FSM: each advance pulse steps to the next counter; remember that a
   // change happened so a frozen value still picks up the new counter once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= SHOW_TOTAL;
         state_chg_r <= 1'b0;
      end else begin
         state_chg_r <= adv_s;
         if (adv_s) begin
            state_r <= next_sel(state_r);
         end else begin
            state_r <= state_r;
         end
      end
   end

   // Indicator LEDs follow the select state one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_r <= 4'b0001;
      end else begin
         led_r <= sel_led(state_r);
      end
   end

   // Route the selected live counter.
   always_comb begin
      sel_value_s = total;
      case (state_r)
         SHOW_TOTAL:  sel_value_s = total;
         SHOW_COND:   sel_value_s = conditional;
         SHOW_UNCOND: sel_value_s = unconditional;
         SHOW_SUCC:   sel_value_s = conditional_success;
         default:     sel_value_s = total;
      endcase
   end

   // Displayed value tracks the counter unless frozen; a selection change
   // overrides the freeze for exactly one load.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_r <= 32'd0;
      end else if (!freeze || state_chg_r) begin
         value_r <= sel_value_s;
      end else begin
         value_r <= value_r;
      end
   end

   // Scan timing: prescaler sets the dwell time, digit index cycles 0..7.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r <= '0;
         digit_r <= 3'd0;
      end else if (presc_r == PRESC_LAST) begin
         presc_r <= '0;
         digit_r <= digit_r + 3'd1;
      end else begin
         presc_r <= presc_r + PW'(1);
         digit_r <= digit_r;
      end
   end

   // Align the current digit to bit 0 and detect a leading zero.
   always_comb begin
      shifted_s = value_r >> {digit_r, 2'b00};
      if ((digit_r != 3'd0) && (shifted_s == 32'd0)) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end
   end

   // Register the digit enable and cathode pattern for the current digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r  <= 8'hFE;
         seg_r <= 8'hC0;
      end else begin
         an_r <= ~(8'd1 << digit_r);
         if (blank_s) begin
            seg_r <= SEG_BLANK;
         end else begin
            seg_r <= hex_to_seg(shifted_s[3:0]);
         end
      end
   end

   assign seg = seg_r;
   assign an  = an_r;
   assign led = led_r;

endmodule

// File: tb/tb_stats_display.sv
// Directed bench for stats_display with a short scan period and debounce window.
module tb_stats_display;

   logic        clk;
   logic        rst;
   logic [31:0] total;
   logic [31:0] conditional;
   logic [31:0] unconditional;
   logic [31:0] conditional_success;
   logic        btn_next;
   logic        freeze;
   logic [7:0]  seg;
   logic [7:0]  an;
   logic [3:0]  led;

   int vectors;
   int miscompares;

   stats_display #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (3)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .total               (total),
      .conditional         (conditional),
      .unconditional       (unconditional),
      .conditional_success (conditional_success),
      .btn_next            (btn_next),
      .freeze              (freeze),
      .seg                 (seg),
      .an                  (an),
      .led                 (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for a fresh scan slot of digit k (bounded), then check its pattern.
   task automatic show(input int k, input logic [7:0] exp_seg);
      logic [7:0] an_exp;
      int n;
      an_exp = ~(8'h01 << k);
      n = 0;
      while (an === an_exp && n < 40) begin
         tick(1);
         n++;
      end
      n = 0;
      while (an !== an_exp && n < 40) begin
         tick(1);
         n++;
      end
      chk($sformatf("an_digit%0d", k), {24'd0, an}, {24'd0, an_exp});
      chk($sformatf("seg_digit%0d", k), {24'd0, seg}, {24'd0, exp_seg});
   endtask

   task automatic press();
      btn_next = 1'b1;
      tick(10);
      btn_next = 1'b0;
      tick(8);
   endtask

   initial begin
      vectors             = 0;
      miscompares         = 0;
      rst                 = 1'b1;
      total               = 32'h0000_00A5;
      conditional         = 32'h0000_00C3;
      unconditional       = 32'h0000_0007;
      conditional_success = 32'h0000_000E;
      btn_next            = 1'b0;
      freeze              = 1'b0;

      // Reset state.
      tick(2);
      rst = 1'b0;
      chk("reset_an",  {24'd0, an},  32'h0000_00FE);
      chk("reset_seg", {24'd0, seg}, 32'h0000_00C0);
      chk("reset_led", {28'd0, led}, 32'h0000_0001);

      // Exact scan phase: value loads at edge 1, digit 0 shows 5 from edge 2,
      // digit index advances every 4 cycles.
      tick(2);
      chk("scan_e2_an",  {24'd0, an},  32'h0000_00FE);
      chk("scan_e2_seg", {24'd0, seg}, 32'h0000_0092);
      tick(3);
      chk("scan_e5_an",  {24'd0, an},  32'h0000_00FD);
      chk("scan_e5_seg", {24'd0, seg}, 32'h0000_0088);
      for (int d = 2; d < 8; d++) begin
         tick(4);
         chk($sformatf("scan_d%0d_an", d), {24'd0, an}, {24'd0, ~(8'h01 << d)});
         chk($sformatf("scan_d%0d_seg", d), {24'd0, seg}, 32'h0000_00FF);
      end
      tick(4);
      chk("scan_wrap_an",  {24'd0, an},  32'h0000_00FE);
      chk("scan_wrap_seg", {24'd0, seg}, 32'h0000_0092);

      // Long press: exactly one advance to conditional.
      press();
      chk("press1_led", {28'd0, led}, 32'h0000_0002);
      show(0, 8'hB0);
      show(1, 8'hC6);
      show(2, 8'hFF);

      // Two-cycle glitch must be rejected.
      btn_next = 1'b1;
      tick(2);
      btn_next = 1'b0;
      tick(10);
      chk("glitch_led", {28'd0, led}, 32'h0000_0002);

      // Remaining presses walk the ring back to total.
      press();
      chk("press2_led", {28'd0, led}, 32'h0000_0004);
      show(0, 8'hF8);
      show(1, 8'hFF);
      press();
      chk("press3_led", {28'd0, led}, 32'h0000_0008);
      show(0, 8'h86);
      press();
      chk("press4_led", {28'd0, led}, 32'h0000_0001);
      show(0, 8'h92);
      show(1, 8'h88);

      // Freeze at total=10 while total ramps to 50.
      total = 32'h0000_0010;
      tick(2);
      freeze = 1'b1;
      conditional = 32'h0000_002B;
      for (int v = 2; v <= 5; v++) begin
         total = 32'h0000_0010 * v;
         tick(3);
      end
      show(0, 8'hC0);
      show(1, 8'hF9);
      show(2, 8'hFF);

      // Press while frozen: conditional captured once, then held.
      press();
      conditional = 32'h0000_0099;
      chk("frz_press_led", {28'd0, led}, 32'h0000_0002);
      show(0, 8'h83);
      show(1, 8'hA4);
      show(2, 8'hFF);

      // Unfreeze: live conditional appears.
      freeze = 1'b0;
      tick(2);
      show(0, 8'h90);
      show(1, 8'h90);

      // Reset during digit 5 with a half-debounced press.
      show(5, 8'hFF);
      btn_next = 1'b1;
      tick(3);
      rst = 1'b1;
      btn_next = 1'b0;
      tick(2);
      rst = 1'b0;
      chk("rst_mid_an",  {24'd0, an},  32'h0000_00FE);
      chk("rst_mid_led", {28'd0, led}, 32'h0000_0001);
      chk("rst_mid_seg", {24'd0, seg}, 32'h0000_00C0);
      tick(20);
      chk("rst_nopulse_led", {28'd0, led}, 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
